// File: rtl/vga_crtc_pkg.sv
// Shared types for the CRT controller: timing config bundle, FSM states,
// counter widths and zero-extension helpers used by the timing generators.
package vga_crtc_pkg;

    localparam int TB_WIDTH  = 8;
    localparam int VB_WIDTH  = 12;
    localparam int CNT_WIDTH = VB_WIDTH + 2;

    typedef struct packed {
        logic                hpol;
        logic                vpol;
        logic [TB_WIDTH-1:0] hbp;
        logic [TB_WIDTH-1:0] hsn;
        logic [TB_WIDTH-1:0] hfp;
        logic [VB_WIDTH-1:0] hvl;
        logic [TB_WIDTH-1:0] vbp;
        logic [TB_WIDTH-1:0] vsn;
        logic [TB_WIDTH-1:0] vfp;
        logic [VB_WIDTH-1:0] vvl;
    } vga_tim_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } crtc_state_e;

    function automatic logic [CNT_WIDTH-1:0] tb_ext(logic [TB_WIDTH-1:0] v);
        return CNT_WIDTH'(v);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] vb_ext(logic [VB_WIDTH-1:0] v);
        return CNT_WIDTH'(v);
    endfunction

endpackage

// File: rtl/vga_crtc_timgen.sv
// One axis timing generator: counts visible, front porch, sync, back porch.
// Ports: clk_i, rst_n_i, en (advance), vl/fp/sn/bp sizes; vis/sync/first/last flags.
module vga_timgen
    import vga_crtc_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] vl,
    input  logic [CNT_WIDTH-1:0] fp,
    input  logic [CNT_WIDTH-1:0] sn,
    input  logic [CNT_WIDTH-1:0] bp,
    output logic                 vis,
    output logic                 sync,
    output logic                 first,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] sync_beg;
    logic [CNT_WIDTH-1:0] sync_end;
    logic [CNT_WIDTH-1:0] last_idx;

    always_comb begin
        sync_beg = vl + fp;
        sync_end = sync_beg + sn;
        last_idx = sync_end + bp - CNT_WIDTH'(1);
        vis      = cnt < vl;
        sync     = (cnt >= sync_beg) && (cnt < sync_end);
        first    = cnt == '0;
        last     = cnt == last_idx;
    end

    // Wrapping on the last count leaves the counter at 0 whenever the
    // controller stops at a boundary, so a new config starts cleanly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_crtc.sv
// CRT controller: frame-boundary config load, h/v sequencing, sync/de/strobes, irq.
// Ports: clk_i, rst_n_i, en_i, cfg_upd_i, cfg_i, irq_clr_i -> ack/busy/pix_req/strobes/syncs/frm_cnt/irq.
module vga_crtc
    import vga_crtc_pkg::*;
#(
    parameter int FRM_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_i,
    input  logic                     cfg_upd_i,
    input  vga_tim_cfg_t             cfg_i,
    input  logic                     irq_clr_i,
    output logic                     cfg_ack_o,
    output logic                     busy_o,
    output logic                     pix_req_o,
    output logic                     line_start_o,
    output logic                     frame_start_o,
    output logic                     de_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic [FRM_CNT_WIDTH-1:0] frm_cnt_o,
    output logic                     irq_o
);

    crtc_state_e  state;
    crtc_state_e  state_nxt;
    vga_tim_cfg_t cfg_act;
    logic         upd_pend;

    logic h_en;
    logic v_en;
    logic frame_end;
    logic h_vis, h_sync, h_first, h_last;
    logic v_vis, v_sync, v_first, v_last;

    assign h_en      = (state == RUN) || (state == DRAIN);
    assign v_en      = h_en & h_last;
    assign frame_end = h_en & h_last & v_last;
    assign pix_req_o = h_en & h_vis & v_vis;

    vga_timgen u_htim (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en      (h_en),
        .vl      (vb_ext(cfg_act.hvl)),
        .fp      (tb_ext(cfg_act.hfp)),
        .sn      (tb_ext(cfg_act.hsn)),
        .bp      (tb_ext(cfg_act.hbp)),
        .vis     (h_vis),
        .sync    (h_sync),
        .first   (h_first),
        .last    (h_last)
    );

    vga_timgen u_vtim (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en      (v_en),
        .vl      (vb_ext(cfg_act.vvl)),
        .fp      (tb_ext(cfg_act.vfp)),
        .sn      (tb_ext(cfg_act.vsn)),
        .bp      (tb_ext(cfg_act.vbp)),
        .vis     (v_vis),
        .sync    (v_sync),
        .first   (v_first),
        .last    (v_last)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving RUN/DRAIN only at frame_end keeps both counters at frame start.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en_i) state_nxt = LOAD;
            end
            LOAD: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (frame_end && !en_i) begin
                    state_nxt = IDLE;
                end else if (frame_end && upd_pend) begin
                    state_nxt = LOAD;
                end else if (!en_i) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_end) begin
                    state_nxt = IDLE;
                end else if (en_i) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o    = 1'b1;
        cfg_ack_o = 1'b0;
        unique case (state)
            IDLE:    busy_o    = 1'b0;
            LOAD:    cfg_ack_o = 1'b1;
            default: ;
        endcase
    end

    // A pulse arriving in the LOAD cycle belongs to the next update.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_act  <= '0;
            upd_pend <= 1'b0;
        end else begin
            if (state == LOAD) cfg_act <= cfg_i;
            upd_pend <= cfg_upd_i | (upd_pend & (state != LOAD));
        end
    end

    // Syncs are gated by h_en so LOAD/IDLE cycles show the inactive level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            de_o          <= 1'b0;
            hsync_o       <= 1'b0;
            vsync_o       <= 1'b0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            frm_cnt_o     <= '0;
            irq_o         <= 1'b0;
        end else begin
            de_o          <= pix_req_o;
            hsync_o       <= (h_en & h_sync) ^ cfg_act.hpol;
            vsync_o       <= (h_en & v_sync) ^ cfg_act.vpol;
            line_start_o  <= h_en & h_first;
            frame_start_o <= h_en & h_first & v_first;
            if (frame_end) frm_cnt_o <= frm_cnt_o + FRM_CNT_WIDTH'(1);
            irq_o         <= frame_start_o | (irq_o & ~irq_clr_i);
        end
    end

endmodule
